sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/coco_sram_pkg.sv | 30 +++
 rtl/sram_arb_pick.sv | 45 ++++
 rtl/sram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/coco_sram_pkg.sv
// -----------------------------------------------------------------------------
// coco_sram_pkg
// Shared definitions for the AVR/CoCo SRAM arbiter:
//   - sram_state_t           : access FSM states (IDLE, ADDR, STROBE, HOLD)
//   - OWNER_COCO / OWNER_AVR : encoding of the owner output and grant
//   - WAIT_TICKS_MIN/MAX     : legal range of the strobe length parameter
//   - wait_ticks_ok()        : range check used at elaboration time
// No ports (package).
// -----------------------------------------------------------------------------
package coco_sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } sram_state_t;

    localparam logic OWNER_COCO = 1'b0;
    localparam logic OWNER_AVR  = 1'b1;

    // The strobe counter is 3 bits wide, so 7 is the longest strobe it can time.
    localparam int WAIT_TICKS_MIN = 1;
    localparam int WAIT_TICKS_MAX = 7;

    function automatic bit wait_ticks_ok(input int ticks);
        return (ticks >= WAIT_TICKS_MIN) && (ticks <= WAIT_TICKS_MAX);
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
// Combinational winner selection between the AVR and CoCo request lines.
// Build option: define SRAM_ARB_RR_EN for round-robin on ties (the port that
// did not win the previous grant wins); otherwise the AVR has fixed priority
// and 'last' is ignored.
// Ports:
//   a_req       in   AVR request
//   c_req       in   CoCo request
//   last        in   previous grantee (OWNER_COCO / OWNER_AVR)
//   grant_valid out  at least one request is pending
//   grant_owner out  selected port (OWNER_COCO / OWNER_AVR)
// -----------------------------------------------------------------------------
module sram_arb_pick
    import coco_sram_pkg::*;
(
    input  logic a_req,
    input  logic c_req,
    input  logic last,
    output logic grant_valid,
    output logic grant_owner
);

`ifdef SRAM_ARB_RR_EN
    always_comb begin
        grant_valid = a_req | c_req;
        if (a_req && c_req) begin
            // Tie: hand the grant to whoever lost last time.
            grant_owner = (last == OWNER_AVR) ? OWNER_COCO : OWNER_AVR;
        end else begin
            grant_owner = a_req ? OWNER_AVR : OWNER_COCO;
        end
    end
`else
    // Fixed priority: the previous grantee has no influence.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant_valid = a_req | c_req;
        grant_owner = a_req ? OWNER_AVR : OWNER_COCO;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous SRAM between the AVR and CoCo ports. Each access runs
// IDLE -> ADDR (1 clk) -> STROBE (WAIT_TICKS clks) -> HOLD (1 clk) -> IDLE, so
// request-to-ack is WAIT_TICKS+2 cycles and the access period WAIT_TICKS+3.
// Build option: SRAM_ARB_RR_EN selects round-robin on simultaneous requests
// (a last-winner register is added); default is fixed AVR priority.
// Parameters: ADDR_W (16), DATA_W (8), WAIT_TICKS (3, legal 1..7).
// Ports:
//   clock_50, reset_n                 clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata         AVR request side
//   a_ack/a_rdata                     AVR one-cycle ack and read data
//   c_req/c_we/c_addr/c_wdata         CoCo request side
//   c_ack/c_rdata                     CoCo one-cycle ack and read data
//   sram_addrbus, sram_dout           registered SRAM address and write data
//   sram_drive                        data pad output enable (writes only)
//   sram_din                          SRAM read data
//   sram_ce_n/sram_oe_n/sram_we_n     active-low SRAM strobes
//   owner                             current/last grantee (0 CoCo, 1 AVR)
//   busy                              high in every state except IDLE
// -----------------------------------------------------------------------------
module sram_arbiter
    import coco_sram_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int WAIT_TICKS = 3
) (
    input  logic              clock_50,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic [ADDR_W-1:0] sram_addrbus,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_drive,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              owner,
    output logic              busy
);

    if (!wait_ticks_ok(WAIT_TICKS)) begin : g_bad_wait_ticks
        $error("sram_arbiter: WAIT_TICKS must be in 1..7");
    end

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_TICKS);

    sram_state_t       state_reg;
    logic [2:0]        cnt_reg;
    logic              acc_we_reg;
    logic              owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              drive_reg;
    logic              ce_n_reg;
    logic              oe_n_reg;
    logic              we_n_reg;
    logic              a_ack_reg;
    logic              c_ack_reg;
    logic [DATA_W-1:0] a_rdata_reg;
    logic [DATA_W-1:0] c_rdata_reg;
    logic              busy_reg;

    logic              grant_valid;
    logic              grant_owner;
    logic              last_winner;

`ifdef SRAM_ARB_RR_EN
    logic last_winner_reg;
    assign last_winner = last_winner_reg;
`else
    assign last_winner = OWNER_COCO;
`endif

    sram_arb_pick u_pick (
        .a_req       (a_req),
        .c_req       (c_req),
        .last        (last_winner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Winner's request fields, latched on the IDLE -> ADDR edge only.
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        sel_we    = (grant_owner == OWNER_AVR) ? a_we    : c_we;
        sel_addr  = (grant_owner == OWNER_AVR) ? a_addr  : c_addr;
        sel_wdata = (grant_owner == OWNER_AVR) ? a_wdata : c_wdata;
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            acc_we_reg  <= 1'b0;
            owner_reg   <= OWNER_COCO;
            addr_reg    <= '0;
            dout_reg    <= '0;
            drive_reg   <= 1'b0;
            ce_n_reg    <= 1'b1;
            oe_n_reg    <= 1'b1;
            we_n_reg    <= 1'b1;
            a_ack_reg   <= 1'b0;
            c_ack_reg   <= 1'b0;
            a_rdata_reg <= '0;
            c_rdata_reg <= '0;
            busy_reg    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_winner_reg <= OWNER_COCO;
`endif
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        state_reg  <= ADDR;
                        owner_reg  <= grant_owner;
                        acc_we_reg <= sel_we;
                        addr_reg   <= sel_addr;
                        dout_reg   <= sel_wdata;
                        drive_reg  <= sel_we;
                        ce_n_reg   <= 1'b0;
                        busy_reg   <= 1'b1;
`ifdef SRAM_ARB_RR_EN
                        last_winner_reg <= grant_owner;
`endif
                    end
                end
                ADDR: begin
                    state_reg <= STROBE;
                    cnt_reg   <= WAIT_INIT;
                    if (acc_we_reg) begin
                        we_n_reg <= 1'b0;
                    end else begin
                        oe_n_reg <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt_reg == 3'd1) begin
                        // Last strobe edge: release strobes, sample read data
                        // into the owner's port only, and raise its ack.
                        state_reg <= HOLD;
                        we_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        if (owner_reg == OWNER_AVR) begin
                            a_ack_reg <= 1'b1;
                            if (!acc_we_reg) begin
                                a_rdata_reg <= sram_din;
                            end
                        end else begin
                            c_ack_reg <= 1'b1;
                            if (!acc_we_reg) begin
                                c_rdata_reg <= sram_din;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                HOLD: begin
                    state_reg <= IDLE;
                    ce_n_reg  <= 1'b1;
                    drive_reg <= 1'b0;
                    a_ack_reg <= 1'b0;
                    c_ack_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign a_ack        = a_ack_reg;
    assign c_ack        = c_ack_reg;
    assign a_rdata      = a_rdata_reg;
    assign c_rdata      = c_rdata_reg;
    assign sram_addrbus = addr_reg;
    assign sram_dout    = dout_reg;
    assign sram_drive   = drive_reg;
    assign sram_ce_n    = ce_n_reg;
    assign sram_oe_n    = oe_n_reg;
    assign sram_we_n    = we_n_reg;
    assign owner        = owner_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter (default build, WAIT_TICKS = 3).
// Cycle numbers count sampling points #1 after each rising edge; a request
// driven at cycle 0 is sampled on edge 1 and its ack is expected at cycle 5.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clock_50 = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, c_req, c_we;
    logic [15:0] a_addr, c_addr;
    logic [7:0]  a_wdata, c_wdata;
    logic        a_ack, c_ack;
    logic [7:0]  a_rdata, c_rdata;
    logic [15:0] sram_addrbus;
    logic [7:0]  sram_dout, sram_din;
    logic        sram_drive, sram_ce_n, sram_oe_n, sram_we_n, owner, busy;

    always #10 clock_50 = ~clock_50;

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_TICKS(3)) dut (
        .clock_50     (clock_50),
        .reset_n      (reset_n),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_ack        (a_ack),
        .a_rdata      (a_rdata),
        .c_req        (c_req),
        .c_we         (c_we),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata),
        .c_ack        (c_ack),
        .c_rdata      (c_rdata),
        .sram_addrbus (sram_addrbus),
        .sram_dout    (sram_dout),
        .sram_drive   (sram_drive),
        .sram_din     (sram_din),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .owner        (owner),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Per-run monitor
    int   cyc, we_low, we_first, oe_low, drive_hi, ce_low;
    int   a_acks[$];
    int   c_acks[$];
    logic [15:0] addr_ack;
    logic [7:0]  dout_ack, rdata_ack;
    bit   a_ack_prev = 0, c_ack_prev = 0;
    bit   drop_a = 1, drop_c = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_mon();
        cyc = 0; we_low = 0; we_first = 0; oe_low = 0; drive_hi = 0; ce_low = 0;
        a_acks.delete();
        c_acks.delete();
        addr_ack = '0; dout_ack = '0; rdata_ack = '0;
    endtask

    // One clock: requesters drop req after the edge that sampled their ack.
    task automatic step();
        @(posedge clock_50);
        #1;
        cyc++;
        if (a_ack_prev && drop_a) a_req = 1'b0;
        if (c_ack_prev && drop_c) c_req = 1'b0;
        a_ack_prev = a_ack;
        c_ack_prev = c_ack;
        if (!sram_we_n) begin
            we_low++;
            if (we_first == 0) we_first = cyc;
        end
        if (!sram_oe_n) oe_low++;
        if (sram_drive) drive_hi++;
        if (!sram_ce_n) ce_low++;
        if (a_ack) begin
            a_acks.push_back(cyc);
            addr_ack = sram_addrbus; dout_ack = sram_dout; rdata_ack = a_rdata;
            $display("txn cyc=%0d port=AVR addr=%h dout=%h rdata=%h", cyc, sram_addrbus, sram_dout, a_rdata);
        end
        if (c_ack) begin
            c_acks.push_back(cyc);
            addr_ack = sram_addrbus; dout_ack = sram_dout; rdata_ack = c_rdata;
            $display("txn cyc=%0d port=CoCo addr=%h dout=%h rdata=%h", cyc, sram_addrbus, sram_dout, c_rdata);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        sram_din = '0;
        #25;
        check("rst_ce_n",  sram_ce_n, 1);
        check("rst_oe_n",  sram_oe_n, 1);
        check("rst_we_n",  sram_we_n, 1);
        check("rst_drive", sram_drive, 0);
        check("rst_acks",  {a_ack, c_ack}, 0);
        check("rst_rdata", {a_rdata, c_rdata}, 0);
        check("rst_addr",  sram_addrbus, 0);
        check("rst_dout",  sram_dout, 0);
        check("rst_owner", owner, 0);
        check("rst_busy",  busy, 0);
        @(negedge clock_50);
        reset_n = 1'b1;
        step();

        // AVR write 7F40 <- A5
        clear_mon();
        a_req = 1; a_we = 1; a_addr = 16'h7F40; a_wdata = 8'hA5;
        repeat (8) step();
        check("wr_ack_cyc",   at(a_acks, 0), 5);
        check("wr_ack_cnt",   a_acks.size(), 1);
        check("wr_c_ack_cnt", c_acks.size(), 0);
        check("wr_we_low",    we_low, 3);
        check("wr_we_first",  we_first, 2);
        check("wr_oe_low",    oe_low, 0);
        check("wr_drive",     drive_hi, 5);
        check("wr_ce_low",    ce_low, 5);
        check("wr_addr",      addr_ack, 16'h7F40);
        check("wr_dout",      dout_ack, 8'hA5);
        check("wr_owner",     owner, 1);
        check("wr_busy_end",  busy, 0);

        // CoCo read 8123 -> 3C; address changes after latching must not matter
        clear_mon();
        c_req = 1; c_we = 0; c_addr = 16'h8123; sram_din = 8'h3C;
        step(); step();
        c_addr = 16'h0000; c_wdata = 8'hFF;
        repeat (6) step();
        check("rd_ack_cyc", at(c_acks, 0), 5);
        check("rd_a_acks",  a_acks.size(), 0);
        check("rd_oe_low",  oe_low, 3);
        check("rd_we_low",  we_low, 0);
        check("rd_drive",   drive_hi, 0);
        check("rd_rdata",   rdata_ack, 8'h3C);
        check("rd_addr",    addr_ack, 16'h8123);
        check("rd_a_rdata", a_rdata, 8'h00);
        check("rd_owner",   owner, 0);
        sram_din = 8'h00;
        step();
        check("rd_hold", c_rdata, 8'h3C);

        // AVR read 0555 -> 5A; CoCo rdata must keep 3C
        clear_mon();
        a_req = 1; a_we = 0; a_addr = 16'h0555; sram_din = 8'h5A;
        repeat (8) step();
        check("rd2_ack_cyc", at(a_acks, 0), 5);
        check("rd2_rdata",   a_rdata, 8'h5A);
        check("rd2_c_rdata", c_rdata, 8'h3C);

        // Tie: both requests on the same edge, AVR first, CoCo 6 cycles later
        clear_mon();
        a_req = 1; a_we = 1; a_addr = 16'h1111; a_wdata = 8'h11;
        c_req = 1; c_we = 1; c_addr = 16'h2222; c_wdata = 8'h22;
        repeat (14) step();
        check("tie_a_ack",  at(a_acks, 0), 5);
        check("tie_c_ack",  at(c_acks, 0), 11);
        check("tie_a_cnt",  a_acks.size(), 1);
        check("tie_c_cnt",  c_acks.size(), 1);
        check("tie_c_addr", addr_ack, 16'h2222);
        check("tie_c_dout", dout_ack, 8'h22);

        // Reset pulse during STROBE of a write, then full restart
        clear_mon();
        a_req = 1; a_we = 1; a_addr = 16'h0042; a_wdata = 8'h99;
        repeat (3) step();
        check("ab_in_strobe", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check("ab_we_n",  sram_we_n, 1);
        check("ab_drive", sram_drive, 0);
        check("ab_ce_n",  sram_ce_n, 1);
        check("ab_busy",  busy, 0);
        check("ab_ack",   a_ack, 0);
        check("ab_rdata", a_rdata, 8'h00);
        check("ab_acks",  a_acks.size(), 0);
        #4 reset_n = 1'b1;
        clear_mon();
        repeat (8) step();
        check("rs_ack_cyc", at(a_acks, 0), 5);
        check("rs_we_low",  we_low, 3);
        check("rs_dout",    dout_ack, 8'h99);

        // a_req held permanently: CoCo starves, AVR period 6
        clear_mon();
        drop_a = 0;
        a_req = 1; a_we = 0; a_addr = 16'h1234;
        c_req = 1; c_we = 0; c_addr = 16'h4321; sram_din = 8'h77;
        repeat (17) step();
        check("st_a0",    at(a_acks, 0), 5);
        check("st_a1",    at(a_acks, 1), 11);
        check("st_a2",    at(a_acks, 2), 17);
        check("st_c_cnt", c_acks.size(), 0);
        a_req = 0; drop_a = 1;
        clear_mon();
        repeat (10) step();
        check("st_c_ack",   at(c_acks, 0), 6);
        check("st_c_rdata", c_rdata, 8'h77);
        check("st_a_cnt",   a_acks.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
